vsample_sched: RTL
==================

Name: vsample_sched

Overview:
- Frame-synchronous scheduler for the AXI4-Stream pixel decimation datapath.
- Taps the input stream handshake without driving it, and tracks column/row position against the programmed frame geometry.
- Latches decimation configuration only at start-of-frame, and produces a per-beat keep strobe that the datapath uses to gate m_axis_tvalid.
- Sequences start/stop at frame boundaries and reports frame count and sticky geometry errors.

Parameters:
CNT_W, 16, width of column/row counters and geometry inputs
FCNT_W, 32, width of completed-frame counter

Ports:
aclk  in  1  clock
areset  in  1  reset; asynchronous, active-high
cfg_w_down  in  1  staged column-decimation enable
cfg_w_phase  in  1  staged kept column parity
cfg_h_down  in  1  staged row-decimation enable
cfg_h_phase  in  1  staged kept row parity
cfg_width  in  CNT_W  pixels per line (>=1)
cfg_height  in  CNT_W  lines per frame (>=1)
ctrl_start  in  1  start pulse
ctrl_stop  in  1  stop pulse
err_clr  in  1  clear sticky errors
mon_tvalid  in  1  tapped s_axis_tvalid
mon_tready  in  1  tapped s_axis_tready
mon_tlast  in  1  tapped s_axis_tlast (EOL)
mon_tuser  in  1  tapped s_axis_tuser[0] (SOF)
smp_keep  out  1  keep current beat (combinational)
state  out  2  0 IDLE, 1 ARMED, 2 RUN, 3 DRAIN
busy  out  1  state is RUN or DRAIN
frame_done  out  1  one-cycle pulse at last beat of a frame
frame_cnt  out  FCNT_W  completed frames, wraps
err_eol_early  out  1  sticky: tlast before col==width-1
err_eol_late  out  1  sticky: no tlast at col==width-1
err_sof_early  out  1  sticky: SOF while col!=0 or row!=0 in RUN/DRAIN

Behaviour:
- beat = mon_tvalid & mon_tready. All counters and state advance only on a beat or a ctrl pulse.
- Reset values: state IDLE, col=0, row=0, all act_* config registers 0, frame_cnt 0, frame_done 0, all errors 0.
- smp_keep is therefore 0 at reset.
- State machine:
  - IDLE: ctrl_start -> ARMED.
  - ARMED: ctrl_stop -> IDLE. Otherwise, a beat with mon_tuser -> RUN, latching cfg_* into act_* registers and setting col=1, row=0 (or col=0, row=1 if mon_tlast on that beat).
  - RUN: ctrl_stop -> DRAIN.
  - DRAIN: the frame_done beat -> IDLE.
  - ctrl_start is ignored outside IDLE.
  - Simultaneous ctrl_start and ctrl_stop: stop wins (IDLE stays IDLE).
- smp_keep:
  - Kept column: ck = !w_down | (col[0]==w_phase).
  - Kept row: rk = !h_down | (row[0]==h_phase).
  - In RUN/DRAIN: smp_keep = mon_tvalid & ck & rk, using act_* values.
  - On the ARMED SOF beat: smp_keep uses cfg_* with col=0, row=0.
  - IDLE, and ARMED non-SOF beats: smp_keep=0.
- Counting in RUN/DRAIN on each beat:
  - tlast: col<=0. If row==act_height-1: row<=0, frame_done=1 next cycle, frame_cnt++. Else row++.
  - No tlast: col++.
- Re-latch: in RUN, a SOF beat with col==0 and row==0 re-latches cfg_* (frame-boundary reconfiguration). In DRAIN no re-latch.
- Errors, all sticky:
  - err_eol_early: beat with tlast and col<act_width-1.
  - err_eol_late: beat without tlast and col==act_width-1. col still increments.
  - err_sof_early: SOF beat with col!=0 or row!=0. Resync col=1, row=0 (or col=0, row=1 if tlast), then re-latch config in RUN.
  - err_clr clears all three. Same-cycle set and clr: set wins.
- Width rule: counters CNT_W bits; col wraps modulo 2^CNT_W, no saturation. Comparisons use act_width/act_height minus 1 computed in CNT_W bits.
- No beats occur while mon_tready=0; counters hold.
- areset asserted mid-frame: immediate return to reset values. Restart requires ctrl_start and a fresh SOF.
- Latency: status outputs are registered, updated one cycle after the causing beat. smp_keep has zero latency.

Test Plan:
- Geometry width=4, height=2, w_down=1 w_phase=0, h_down=1 h_phase=0; start, then one clean frame -> smp_keep on beats (r0,c0),(r0,c2) only; frame_done pulse after beat 8; frame_cnt=1; no errors.
- Same geometry, w_phase=1 h_phase=1, both downs=0 in frame 2 -> frame 1 keeps (r1,c1),(r1,c3); frame 2 keeps all 8 beats; cfg changed mid-frame 1 has no effect until SOF.
- Beats before SOF in ARMED -> smp_keep=0, counters 0; ctrl_stop in ARMED -> IDLE.
- Line with tlast at col 2 (width=4) -> err_eol_early=1; line of 5 beats -> err_eol_late=1; err_clr -> both 0.
- ctrl_stop at (r0,c1) -> state DRAIN, remaining beats still gated; frame_done -> IDLE, frame_cnt incremented.
- SOF at (r1,c2) -> err_sof_early=1, col=1 row=0; areset mid-frame -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/vsample_sched.sv
// vsample_sched: frame-synchronous keep-strobe scheduler for the pixel
// decimation datapath. It passively taps the input stream handshake, tracks
// the column/row position against the programmed frame geometry and emits a
// per-beat keep strobe. It also sequences start/stop on frame boundaries and
// reports a frame counter and sticky geometry errors.
module vsample_sched #(
    parameter int CNT_W  = 16,
    parameter int FCNT_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_w_down,
    input  logic              cfg_w_phase,
    input  logic              cfg_h_down,
    input  logic              cfg_h_phase,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              err_clr,
    input  logic              mon_tvalid,
    input  logic              mon_tready,
    input  logic              mon_tlast,
    input  logic              mon_tuser,
    output logic              smp_keep,
    output logic [1:0]        state,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_eol_early,
    output logic              err_eol_late,
    output logic              err_sof_early
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    // Registered state
    state_t             r_state;
    logic [CNT_W-1:0]   r_col;
    logic [CNT_W-1:0]   r_row;
    logic               r_act_w_down;
    logic               r_act_w_phase;
    logic               r_act_h_down;
    logic               r_act_h_phase;
    logic [CNT_W-1:0]   r_act_width;
    logic [CNT_W-1:0]   r_act_height;
    logic               r_frame_done;
    logic [FCNT_W-1:0]  r_frame_cnt;
    logic               r_err_eol_early;
    logic               r_err_eol_late;
    logic               r_err_sof_early;

    // Decoded handshake and state
    logic               w_beat;
    logic               w_sof;
    logic               w_armed;
    logic               w_run;
    logic               w_active;
    logic               w_use_cfg;
    logic               w_origin;

    // Effective configuration and position for the current beat
    logic               w_eff_w_down;
    logic               w_eff_w_phase;
    logic               w_eff_h_down;
    logic               w_eff_h_phase;
    logic [CNT_W-1:0]   w_eff_width;
    logic [CNT_W-1:0]   w_eff_height;
    logic [CNT_W-1:0]   w_eff_col;
    logic [CNT_W-1:0]   w_eff_row;
    logic [CNT_W-1:0]   w_wm1;
    logic [CNT_W-1:0]   w_hm1;

    logic               w_eol_at;
    logic               w_last_row;
    logic               w_keep_col;
    logic               w_keep_row;
    logic               w_done;
    logic               w_set_eol_early;
    logic               w_set_eol_late;
    logic               w_set_sof_early;

    assign w_beat   = mon_tvalid & mon_tready;
    assign w_sof    = w_beat & mon_tuser;
    assign w_armed  = (r_state == ST_ARMED);
    assign w_run    = (r_state == ST_RUN);
    assign w_active = (r_state == ST_RUN) | (r_state == ST_DRAIN);

    // A SOF beat that (re)starts a frame is judged with the staged config;
    // DRAIN never re-latches, so it keeps using the active config.
    assign w_use_cfg = w_sof & (w_armed | w_run);
    // Any SOF beat outside IDLE is treated as pixel (r0,c0), which also
    // covers the resync after an early SOF.
    assign w_origin  = w_sof & (r_state != ST_IDLE);

    // Select the configuration that governs the current beat
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_eff_w_down  = r_act_w_down;
        w_eff_w_phase = r_act_w_phase;
        w_eff_h_down  = r_act_h_down;
        w_eff_h_phase = r_act_h_phase;
        w_eff_width   = r_act_width;
        w_eff_height  = r_act_height;
        if (w_use_cfg) begin
            w_eff_w_down  = cfg_w_down;
            w_eff_w_phase = cfg_w_phase;
            w_eff_h_down  = cfg_h_down;
            w_eff_h_phase = cfg_h_phase;
            w_eff_width   = cfg_width;
            w_eff_height  = cfg_height;
        end
    end

    assign w_eff_col  = w_origin ? '0 : r_col;
    assign w_eff_row  = w_origin ? '0 : r_row;
    assign w_wm1      = w_eff_width - CNT_ONE;
    assign w_hm1      = w_eff_height - CNT_ONE;
    assign w_eol_at   = (w_eff_col == w_wm1);
    assign w_last_row = (w_eff_row == w_hm1);

    assign w_keep_col = ~w_eff_w_down | (w_eff_col[0] == w_eff_w_phase);
    assign w_keep_row = ~w_eff_h_down | (w_eff_row[0] == w_eff_h_phase);
    assign smp_keep   = mon_tvalid & w_keep_col & w_keep_row &
                        (w_active | (w_armed & w_sof));

    assign w_done          = w_beat & w_active & mon_tlast & w_last_row;
    assign w_set_eol_early = w_beat & w_active & mon_tlast & (w_eff_col < w_wm1);
    assign w_set_eol_late  = w_beat & w_active & ~mon_tlast & w_eol_at;
    assign w_set_sof_early = w_sof & w_active & ((r_col != '0) | (r_row != '0));

    // Control FSM and column/row position tracking
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_start && !ctrl_stop) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (ctrl_stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_sof) begin
                        r_state <= ST_RUN;
                        r_col   <= mon_tlast ? '0 : CNT_ONE;
                        r_row   <= mon_tlast ? CNT_ONE : '0;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_beat) begin
                        if (mon_tlast) begin
                            r_col <= '0;
                            r_row <= w_last_row ? '0 : w_eff_row + CNT_ONE;
                        end else begin
                            r_col <= w_eff_col + CNT_ONE;
                            r_row <= w_eff_row;
                        end
                    end
                    if (w_done && ((r_state == ST_DRAIN) || ctrl_stop)) begin
                        r_state <= ST_IDLE;
                    end else if ((r_state == ST_RUN) && ctrl_stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture staged decimation config at frame start / frame-boundary SOF
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_act_w_down  <= 1'b0;
            r_act_w_phase <= 1'b0;
            r_act_h_down  <= 1'b0;
            r_act_h_phase <= 1'b0;
            r_act_width   <= '0;
            r_act_height  <= '0;
        end else if (w_use_cfg && !(w_armed && ctrl_stop)) begin
            r_act_w_down  <= cfg_w_down;
            r_act_w_phase <= cfg_w_phase;
            r_act_h_down  <= cfg_h_down;
            r_act_h_phase <= cfg_h_phase;
            r_act_width   <= cfg_width;
            r_act_height  <= cfg_height;
        end
    end

    // Frame completion pulse, frame counter and sticky errors (set beats clear)
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_frame_done    <= 1'b0;
            r_frame_cnt     <= '0;
            r_err_eol_early <= 1'b0;
            r_err_eol_late  <= 1'b0;
            r_err_sof_early <= 1'b0;
        end else begin
            r_frame_done    <= w_done;
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + FCNT_ONE;
            end
            r_err_eol_early <= w_set_eol_early | (r_err_eol_early & ~err_clr);
            r_err_eol_late  <= w_set_eol_late  | (r_err_eol_late  & ~err_clr);
            r_err_sof_early <= w_set_sof_early | (r_err_sof_early & ~err_clr);
        end
    end

    assign state         = r_state;
    assign busy          = w_active;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
    assign err_eol_early = r_err_eol_early;
    assign err_eol_late  = r_err_eol_late;
    assign err_sof_early = r_err_sof_early;

endmodule
